serial_add_sub: RTL and testbench

Bit-serial, multi-cycle adder/subtractor with a start/done handshake. It computes the same function as the lab's combinational 4-bit binary subtractor: S = A + B when m=0, and S = A − B (A + ~B + 1) when m=1, with carry-out c and two's-complement overflow v. It uses one full-adder slice, iterated LSB-first. It is the sequential counterpart that downstream lab datapaths drive through a handshake instead of settling combinationally.

---
 rtl/serial_add_sub_pkg.sv | 22 ++
 rtl/full_adder.sv | 20 ++
 rtl/serial_add_sub.sv | 126 ++++++++++++
 tb/tb_serial_add_sub.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg
//   Definitions shared by the bit-serial adder/subtractor and its users:
//   - state_e      : FSM state encoding (IDLE, SHIFT, DONE)
//   - ADDSUB_W     : default operand width
//   - cnt_width()  : width of the bit counter for a given operand width
package serial_add_sub_pkg;

   localparam int ADDSUB_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // The counter runs 0..W-1, so $clog2(W) bits are enough.
   // The guard keeps the result at least 1 bit wide.
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder
//   One-bit full adder. This is the single arithmetic slice that the
//   serial datapath iterates over the operand bits.
//   Ports:
//     a, b  : operand bits
//     cin   : carry in
//     s     : sum bit
//     cout  : carry out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub
//   Bit-serial adder/subtractor.
//   m=0 gives S = A + B.
//   m=1 gives S = A - B, computed as A + ~B + 1.
//   The unit also reports the carry out (c) and the two's-complement
//   overflow (v). One full-adder slice is iterated LSB first, so one
//   operation takes W cycles in SHIFT plus one cycle in DONE.
//
//   Ports:
//     clk, rst_n : clock; asynchronous active-low reset
//     start      : operation request
//     A, B, m    : operands and mode, sampled on the accepting edge only
//     busy       : operation in progress
//     done       : one-cycle completion pulse
//     S, c, v    : registered result, held until the next completion
//     dbg_state  : current FSM state, for observation only
//
//   Handshake: start is accepted on a rising edge where busy=0 (IDLE or
//   DONE). A, B and m are sampled on that same edge. busy is then high for
//   W cycles. done is high for exactly one cycle, and S/c/v are updated on
//   entry to that cycle. start while busy=1 is ignored. Asserting start
//   during the done cycle begins the next operation back to back.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int W = ADDSUB_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         m,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] S,
   output logic         c,
   output logic         v,
   output state_e       dbg_state
);

   localparam int CW = cnt_width(W);
   localparam logic [CW-1:0] CNT_LAST   = CW'(W - 1);
   localparam logic [CW-1:0] CNT_MSB_IN = CW'(W - 2);

   state_e        state, next_state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  a_sr, b_sr, r_sr;
   logic          carry;
   logic          cmsb_in;
   logic          fa_s, fa_cout;

   // Operand bits are taken from the LSB of the shift registers.
   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // FSM next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: next_state = start ? SHIFT : IDLE;
         SHIFT:      if (cnt == CNT_LAST) next_state = DONE;
         default:    next_state = IDLE;
      endcase
   end

   assign busy      = (state == SHIFT);
   assign done      = (state == DONE);
   assign dbg_state = state;

   // Datapath: operand load, serial shift and result capture.
   // Subtraction reuses the adder: B is inverted on load and the carry
   // is seeded with m.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         r_sr    <= '0;
         carry   <= 1'b0;
         cmsb_in <= 1'b0;
         cnt     <= '0;
         S       <= '0;
         c       <= 1'b0;
         v       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_sr  <= A;
                  b_sr  <= B ^ {W{m}};
                  carry <= m;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               r_sr  <= {fa_s, r_sr[W-1:1]};
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               carry <= fa_cout;
               cnt   <= cnt + 1'b1;
               // Carry produced by bit W-2 is the carry into the MSB.
               if (cnt == CNT_MSB_IN) cmsb_in <= fa_cout;
               // The last sum bit is not yet in r_sr, so merge it directly.
               if (cnt == CNT_LAST) begin
                  S <= {fa_s, r_sr[W-1:1]};
                  c <= fa_cout;
                  v <= cmsb_in ^ fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;
   import serial_add_sub_pkg::*;

   localparam int W = 4;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         m = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         busy, done, c, v;
   logic [W-1:0] S;
   state_e       dbg_state;

   always #5 clk = ~clk;

   serial_add_sub #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .A         (A),
      .B         (B),
      .m         (m),
      .busy      (busy),
      .done      (done),
      .S         (S),
      .c         (c),
      .v         (v),
      .dbg_state (dbg_state)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Scoreboard.
   // exp_q holds the expected {S,c,v} of accepted operations.
   // due_q holds the cycle index in which each operation's done is due.
   logic [W+1:0] exp_q[$];
   int           due_q[$];
   logic [W+1:0] held = '0;

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference result from plain integer arithmetic.
   // c is the unsigned carry for add, or "no borrow" (A >= B) for subtract.
   // v is set when the exact signed result falls outside the W-bit range.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic mm);
      int ua, ub, sa, sb, ex, sum;
      logic cc, vv;
      logic [W-1:0] s;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (mm) begin
         ex  = sa - sb;
         sum = ua - ub;
         cc  = (ua >= ub);
      end else begin
         ex  = sa + sb;
         sum = ua + ub;
         cc  = (sum >= (1 << W));
      end
      vv = (ex > (1 << (W - 1)) - 1) || (ex < -(1 << (W - 1)));
      s  = sum[W-1:0];
      return {s, cc, vv};
   endfunction

   // ---------------- model: acceptance at each rising edge ----------------
   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         due_q.delete();
         held = '0;
      end else begin
         if (start && !(due_q.size() > 0 && cyc < due_q[0])) begin
            exp_q.push_back(model(A, B, m));
            due_q.push_back(cyc + 1 + W);
         end
      end
      cyc++;
   end

   // ---------------- compare: every cycle on the falling edge ----------------
   always @(negedge clk) begin
      logic exp_done, exp_busy;
      if (rst_n) begin
         exp_done = (due_q.size() > 0) && (due_q[0] == cyc);
         exp_busy = (due_q.size() > 0) && (cyc < due_q[0]);
         check_val("busy", 32'(busy), 32'(exp_busy));
         check_val("done", 32'(done), 32'(exp_done));
         if (exp_done) begin
            held = exp_q.pop_front();
            void'(due_q.pop_front());
         end
         check_val("result_scv", 32'({S, c, v}), 32'(held));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_now(input logic [W-1:0] a, input logic [W-1:0] b, input logic mm);
      A = a;
      B = b;
      m = mm;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic mm);
      @(negedge clk);
      start_now(a, b, mm);
   endtask

   // Bounded wait for done.
   // Entered in the first busy cycle, so done must arrive W cycles later.
   task automatic wait_done(input bit scramble);
      int n;
      n = 0;
      while (!done && n < W + 4) begin
         if (scramble) begin
            A = W'($urandom_range(0, (1 << W) - 1));
            B = W'($urandom_range(0, (1 << W) - 1));
            m = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         n++;
      end
      check_val("latency", 32'(n), 32'(W));
   endtask

   // ---------------- directed vectors ----------------
   logic [W-1:0] ta[7];
   logic [W-1:0] tb[7];
   logic         tm[7];
   logic [W+1:0] texp[7];

   initial begin
      int dn;
      ta[0] = 4'b0111; tb[0] = 4'b0010; tm[0] = 1'b1; texp[0] = 6'b0101_1_0;
      ta[1] = 4'b1010; tb[1] = 4'b0001; tm[1] = 1'b1; texp[1] = 6'b1001_1_0;
      ta[2] = 4'b1111; tb[2] = 4'b1101; tm[2] = 1'b1; texp[2] = 6'b0010_1_0;
      ta[3] = 4'b0011; tb[3] = 4'b1110; tm[3] = 1'b1; texp[3] = 6'b0101_0_0;
      ta[4] = 4'b0111; tb[4] = 4'b1000; tm[4] = 1'b1; texp[4] = 6'b1111_0_1;
      ta[5] = 4'b0111; tb[5] = 4'b0001; tm[5] = 1'b0; texp[5] = 6'b1000_0_1;
      ta[6] = 4'b1000; tb[6] = 4'b1000; tm[6] = 1'b0; texp[6] = 6'b0000_1_1;

      // Reset values
      repeat (2) @(negedge clk);
      check_val("rst_busy", 32'(busy), 32'(0));
      check_val("rst_done", 32'(done), 32'(0));
      check_val("rst_scv", 32'({S, c, v}), 32'(0));
      check_val("rst_state", 32'(dbg_state), 32'(IDLE));
      rst_n = 1'b1;

      // Hand-computed literals pin the reference model
      for (int i = 0; i < 7; i++)
         check_val($sformatf("model_vec%0d", i), 32'(model(ta[i], tb[i], tm[i])), 32'(texp[i]));

      // Directed vectors through the DUT, with exact latency
      for (int i = 0; i < 7; i++) begin
         issue(ta[i], tb[i], tm[i]);
         wait_done(1'b0);
         check_val($sformatf("dut_vec%0d", i), 32'({S, c, v}), 32'(texp[i]));
      end

      // Asynchronous reset in the middle of an operation
      issue(4'b0111, 4'b0010, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("midrst_busy", 32'(busy), 32'(0));
      check_val("midrst_done", 32'(done), 32'(0));
      check_val("midrst_scv", 32'({S, c, v}), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int k = 0; k < W + 3; k++) begin
         @(negedge clk);
         if (done) dn++;
      end
      check_val("midrst_no_done", 32'(dn), 32'(0));

      // A start while busy is ignored: exactly one done pulse
      issue(4'b0101, 4'b0011, 1'b0);
      dn = 0;
      for (int k = 0; k < W + 4; k++) begin
         if (k == 0) begin
            A = 4'b1111; B = 4'b0001; m = 1'b1; start = 1'b1;
         end
         if (k == 2) start = 1'b0;
         @(negedge clk);
         if (done) dn++;
      end
      check_val("busy_start_one_done", 32'(dn), 32'(1));
      check_val("busy_start_result", 32'({S, c, v}), 32'(6'b1000_0_1));

      // Back-to-back: start during the done cycle
      issue(4'b0111, 4'b0010, 1'b1);
      wait_done(1'b0);
      start_now(4'b0000, 4'b0000, 1'b0);
      check_val("b2b_hold", 32'({S, c, v}), 32'(6'b0101_1_0));
      wait_done(1'b0);
      check_val("b2b_result", 32'({S, c, v}), 32'(0));

      // Input stability: operands change every cycle during SHIFT
      issue(4'b0011, 4'b1110, 1'b1);
      wait_done(1'b1);
      check_val("stable_result", 32'({S, c, v}), 32'(6'b0101_0_0));

      // Randomized operations; the compare process checks every cycle
      for (int i = 0; i < 60; i++) begin
         logic [W-1:0] ra, rb;
         logic rm;
         ra = W'($urandom_range(0, (1 << W) - 1));
         rb = W'($urandom_range(0, (1 << W) - 1));
         rm = 1'($urandom_range(0, 1));
         if (i > 0 && $urandom_range(0, 1) == 1) begin
            start_now(ra, rb, rm);
         end else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(ra, rb, rm);
         end
         wait_done(1'($urandom_range(0, 1)));
      end

      repeat (W + 2) @(negedge clk);
      check_val("queue_drained", 32'(exp_q.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish (checks=%0d errors=%0d)", checks, errors);
      $fatal(1);
   end

endmodule
